// File: rtl/axis_sample_checker_if.sv
// Bundles the config write port, the AXI-Stream sink and the status wires of the
// counting-word stream checker into one port group.
interface axis_sample_checker_if #(
    parameter int unsigned ERRCNT_W = 16
);
    // Config: a write is taken on every cycle where cfg_wvalid=1 (cfg_wready is tied high).
    // Stream: a beat transfers on a rising edge where axis_tvalid & axis_tready are both 1;
    // the master must hold tvalid/tdata/tkeep/tlast stable until that edge, the sink may
    // raise or drop tready on any cycle.
    logic                cfg_wvalid;
    logic [31:0]         cfg_wdata;
    logic                cfg_wready;

    logic [31:0]         axis_tdata;
    logic [3:0]          axis_tkeep;
    logic                axis_tlast;
    logic                axis_tvalid;
    logic                axis_tready;

    logic [26:0]         stat_wordCount;
    logic [ERRCNT_W-1:0] stat_errCount;
    logic                stat_done;
    logic                stat_error;

    modport master (
        output cfg_wvalid, cfg_wdata,
        output axis_tdata, axis_tkeep, axis_tlast, axis_tvalid,
        input  cfg_wready, axis_tready,
        input  stat_wordCount, stat_errCount, stat_done, stat_error
    );

    modport slave (
        input  cfg_wvalid, cfg_wdata,
        input  axis_tdata, axis_tkeep, axis_tlast, axis_tvalid,
        output cfg_wready, axis_tready,
        output stat_wordCount, stat_errCount, stat_done, stat_error
    );
endinterface

// File: rtl/axis_sample_checker.sv
// AXI-Stream sink that checks one packet of the counting ramp {5'd0, ctr}, with
// saturating error count, sticky done/error and optional LFSR-throttled tready.
module axis_sample_checker #(
    parameter int unsigned ERRCNT_W  = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  axis_aclk,
    input  logic                  axis_areset,
    axis_sample_checker_if.slave  s_axis,
    output logic [1:0]            o_dbg_state,
    output logic [31:0]           o_dbg_cfg
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ERRCNT_W-1:0] ERR_ONE  = {{(ERRCNT_W-1){1'b0}}, 1'b1};
    localparam logic [26:0]         WORD_ONE = 27'd1;

    state_t              r_state;
    logic [31:0]         r_cfg;
    logic                r_tready;
    logic [15:0]         r_lfsr;
    logic [26:0]         r_exp;
    logic [26:0]         r_word_count;
    logic [ERRCNT_W-1:0] r_err_count;
    logic                r_done;
    logic                r_error;

    state_t              w_state_next;
    logic [15:0]         w_lfsr_step;
    logic [15:0]         w_lfsr_next;
    logic                w_throttle_next;
    logic                w_start;
    logic                w_accept;
    logic                w_last_word;
    logic                w_bad;
    logic                w_finish;

    always_comb begin
        w_lfsr_step = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        w_start     = s_axis.cfg_wvalid & s_axis.cfg_wdata[31];
        // A config write owns its cycle: any handshake coinciding with it is ignored.
        w_accept    = s_axis.axis_tvalid & r_tready & ~s_axis.cfg_wvalid & (r_state == ST_RUN);
        w_last_word = (r_exp == {1'b0, r_cfg[25:0]});
        w_bad       = (s_axis.axis_tdata != {5'd0, r_exp})
                    | (s_axis.axis_tkeep != 4'hf)
                    | (s_axis.axis_tlast != w_last_word);
        w_finish    = w_accept & (s_axis.axis_tlast | w_last_word);

        w_state_next    = r_state;
        w_lfsr_next     = r_lfsr;
        w_throttle_next = r_cfg[30];
        if (s_axis.cfg_wvalid) begin
            w_throttle_next = s_axis.cfg_wdata[30];
            if (w_start) begin
                w_state_next = ST_RUN;
                w_lfsr_next  = LFSR_SEED;
            end else begin
                w_state_next = ST_IDLE;
            end
        end else if (r_state == ST_RUN) begin
            w_lfsr_next = w_lfsr_step;
            if (w_finish) begin
                w_state_next = ST_DONE;
            end
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            r_state      <= ST_IDLE;
            r_cfg        <= '0;
            r_tready     <= 1'b0;
            r_lfsr       <= LFSR_SEED;
            r_exp        <= '0;
            r_word_count <= '0;
            r_err_count  <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_lfsr   <= w_lfsr_next;
            // Ready for the next cycle is decided from where the FSM and LFSR are headed.
            r_tready <= (w_state_next == ST_RUN) & (~w_throttle_next | w_lfsr_next[0]);

            if (s_axis.cfg_wvalid) begin
                r_cfg <= s_axis.cfg_wdata;
            end

            if (w_start) begin
                r_exp        <= '0;
                r_word_count <= '0;
                r_err_count  <= '0;
                r_done       <= 1'b0;
                r_error      <= 1'b0;
            end else if (w_accept) begin
                r_exp        <= r_exp + WORD_ONE;
                r_word_count <= r_word_count + WORD_ONE;
                if (w_bad) begin
                    r_error <= 1'b1;
                    if (r_err_count != '1) begin
                        r_err_count <= r_err_count + ERR_ONE;
                    end
                end
                if (w_finish) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign s_axis.cfg_wready     = 1'b1;
    assign s_axis.axis_tready    = r_tready;
    assign s_axis.stat_wordCount = r_word_count;
    assign s_axis.stat_errCount  = r_err_count;
    assign s_axis.stat_done      = r_done;
    assign s_axis.stat_error     = r_error;

    assign o_dbg_state = r_state;
    assign o_dbg_cfg   = r_cfg;
endmodule
